// File: rtl/serial_add_unit.sv
// rtl/serial_add_unit.sv - bit-serial adder, LSB first, one full-adder slice per clock
// Define SERIAL_ADD_SUB_EN to add the sub input (a - b - cin, cout=1 means no borrow).
module serial_add_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             bit_s;
  logic             carry_next;
  logic [WIDTH-1:0] part_shift;
  logic [WIDTH-1:0] load_b;
  logic             load_c;

  assign bit_s      = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // The new bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_part_one
      assign part_shift = bit_s;
    end else begin : g_part_multi
      assign part_shift = {bit_s, part_q[WIDTH-1:1]};
    end
  endgenerate

`ifdef SERIAL_ADD_SUB_EN
  assign load_b = sub ? ~b : b;
  assign load_c = sub ? ~cin : cin;
`else
  assign load_b = b;
  assign load_c = cin;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = load_b;
          carry_d = load_c;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_next;
        part_d  = part_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          sum_d   = part_shift;
          cout_d  = carry_next;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      part_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule
